mcpu_ctrl: RTL and testbench
============================

// Module: mcpu_ctrl
// PURPOSE
//  Multi-cycle control FSM, successor to the single-cycle SCPU control path. Moore machine
//  sequencing FETCH/DECODE/EXEC/MEM/WB for a MIPS subset over a shared datapath.
//  Adds parametrised memory wait states, a sticky illegal-opcode trap and a retired-instruction
//  counter. Sits between the IR opcode field / ALU zero flag and the multi-cycle datapath muxes.
// PARAMETERS
//  MEM_WAIT  0  extra wait cycles per memory access (fetch, load, store); 0 = 1-cycle access
//  CNT_W     16 width of instr_cnt
// PORTS
//  CLK         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-low
//  opcode      in   6      Instr[31:26], valid from DECODE onward
//  zero        in   1      ALU zero flag
//  PCWrite     out  1      unconditional PC load
//  PCWriteCond out  1      branch qualifier
//  pc_en       out  1      PCWrite | (PCWriteCond & zero)
//  IorD        out  1      memory address select: 0 = PC, 1 = ALUOut
//  MemRead     out  1      memory read
//  MemWr       out  1      memory write
//  IRWrite     out  1      instruction register load
//  M2R         out  1      write-back select: 1 = MDR, 0 = ALUOut
//  RegDst      out  1      1 = rd, 0 = rt
//  regWr       out  1      register file write
//  ALUSrcA     out  1      0 = PC, 1 = A
//  ALUSrcB     out  2      00 = B, 01 = 4, 10 = Imm32, 11 = Imm32<<2
//  ALUop       out  2      00 = add, 01 = sub, 10 = funct
//  PCSource    out  2      00 = ALU, 01 = ALUOut, 10 = jumpPC
//  state       out  4      current state encoding, for debug
//  retire      out  1      1-cycle pulse in the final cycle of each instruction
//  trap        out  1      sticky illegal-opcode flag
//  instr_cnt   out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=FETCH, wait counter=0, instr_cnt=0, trap=0.
//   All control outputs, including retire and pc_en, are forced to 0 while reset=0.
//  Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
//   Any other opcode is illegal.
//  State outputs; unlisted outputs are 0.
//   FETCH   MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00;
//           IRWrite=1 and PCWrite=1 only on the cycle where wcnt==MEM_WAIT.
//   DECODE  ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by opcode:
//           lw/sw->MEMADDR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX, illegal->TRAP.
//   MEMADDR ALUSrcA=1, ALUSrcB=10, ALUop=00. lw->MEMRD, sw->MEMWR.
//   MEMRD   MemRead=1, IorD=1; ->MEMWB when wcnt==MEM_WAIT.
//   MEMWB   regWr=1, M2R=1, RegDst=0; retire.
//   MEMWR   MemWr=1 on every cycle of the state, IorD=1; retire and ->FETCH when wcnt==MEM_WAIT.
//   EXEC    ALUSrcA=1, ALUSrcB=00, ALUop=10.
//   RWB     regWr=1, RegDst=1, M2R=0; retire.
//   BRANCH  ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01; retire.
//   JUMP    PCWrite=1, PCSource=10; retire.
//   ADDIEX  ALUSrcA=1, ALUSrcB=10, ALUop=00.
//   ADDIWB  regWr=1, RegDst=0, M2R=0; retire.
//   TRAP    trap=1, every strobe 0. Absorbing; exits only through reset.
//  Every retiring state returns to FETCH. instr_cnt increments on the clock edge ending a
//   retire cycle and wraps from all-ones to 0.
//  Wait counter: counts 0..MEM_WAIT in FETCH/MEMRD/MEMWR, clears on every state exit.
//   Width is max(1, $clog2(MEM_WAIT+1)).
//  Latency in cycles, W = MEM_WAIT: R 4+W, lw 5+2W, sw 4+2W, beq 3+W, j 3+W, addi 4+W.
//  pc_en is combinational from the state decode and zero; zero is ignored outside BRANCH.
//  Reset mid-instruction: abandoned immediately; first FETCH cycle follows reset release.
// STRUCTURE
//  Shared header mcpu_defs.vh: state encodings S_FETCH..S_TRAP (4 bits), opcode constants,
//   ALUop / ALUSrcB / PCSource codes. The same header is used by the datapath and the bench.
//  Sub-module mcpu_wait_ctr (params MEM_WAIT): inputs en, clr; output done = (wcnt==MEM_WAIT).
//  Top level: state register, next-state logic, output decode, instr_cnt register.
// TESTING
//  1 R-type, MEM_WAIT=0: state FETCH,DECODE,EXEC,RWB; regWr=RegDst=1 and retire in cycle 4;
//    instr_cnt 0->1.
//  2 lw, MEM_WAIT=2: 9 cycles; IRWrite only in cycle 3; MemRead=IorD=1 in cycles 6-8;
//    M2R=regWr=1 in cycle 9.
//  3 beq with zero=1: pc_en=1 in cycle 3. Same with zero=0: pc_en=0, retire=1.
//    j: PCWrite=1, PCSource=10 in cycle 3.
//  4 opcode=111111: trap=1 from cycle 3, held for 20 cycles with all strobes 0;
//    reset pulse clears trap, FETCH resumes.
//  5 reset asserted during MEMWR (MEM_WAIT=3): MemWr drops to 0 at once; instr_cnt=0;
//    first post-release cycle is FETCH.
//  6 CNT_W=4: 17 back-to-back addi; instr_cnt reads 0 after the 16th and 1 after the 17th.

Source files
------------

// File: rtl/mcpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: state encodings, opcodes,
// datapath mux codes and the bundled control-strobe word.
package mcpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRwb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_wr;
    logic       ir_write;
    logic       m2r;
    logic       reg_dst;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Controller <-> datapath signal bundle. master = controller side, slave = datapath side.
interface mcpu_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       opcode;
  logic             zero;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             pc_en;
  logic             IorD;
  logic             MemRead;
  logic             MemWr;
  logic             IRWrite;
  logic             M2R;
  logic             RegDst;
  logic             regWr;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUop;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             retire;
  logic             trap;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, zero,
    output PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWr, IRWrite, M2R, RegDst, regWr,
           ALUSrcA, ALUSrcB, ALUop, PCSource, state, retire, trap, instr_cnt
  );

  modport slave (
    output opcode, zero,
    input  PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWr, IRWrite, M2R, RegDst, regWr,
           ALUSrcA, ALUSrcB, ALUop, PCSource, state, retire, trap, instr_cnt
  );
endinterface

// File: rtl/mcpu_ctrl_wait_ctr.sv
// Memory wait-state counter: counts 0..MEM_WAIT while enabled, done marks the final cycle.
module mcpu_ctrl_wait_ctr #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic CLK,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic done
);
  localparam int unsigned WcntW = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);

  logic [WcntW-1:0] wcnt_q, wcnt_d;

  assign done = (wcnt_q == WcntW'(MEM_WAIT));

  always_comb begin
    wcnt_d = wcnt_q;
    if (clr) begin
      wcnt_d = '0;
    end else if (en && !done) begin
      wcnt_d = wcnt_q + WcntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle Moore control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait states,
// sticky illegal-opcode trap and retired-instruction counter.
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input logic         CLK,
  input logic         reset,
  mcpu_ctrl_if.master bus
);
  state_e           state_q, state_d;
  ctrl_t            ctrl, ctrl_out;
  logic             wait_en, wait_clr, wait_done;
  logic             retire_raw;
  logic [CNT_W-1:0] cnt_q;

  mcpu_ctrl_wait_ctr #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .CLK  (CLK),
    .reset(reset),
    .en   (wait_en),
    .clr  (wait_clr),
    .done (wait_done)
  );

  assign wait_en  = state_q inside {StFetch, StMemRd, StMemWr};
  assign wait_clr = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   if (wait_done) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr: state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (wait_done) state_d = StMemWb;
      StMemWr:   if (wait_done) state_d = StFetch;
      StExec:    state_d = StRwb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StRwb, StBranch, StJump, StAddiWb: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    retire_raw = 1'b0;
    case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluAdd;
        ctrl.pc_source = PcAlu;
        ctrl.ir_write  = wait_done;
        ctrl.pc_write  = wait_done;
      end
      StDecode: ctrl.alu_src_b = SrcBImmSh;
      StMemAddr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_wr = 1'b1;
        ctrl.m2r    = 1'b1;
        retire_raw  = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_wr = 1'b1;
        ctrl.iord   = 1'b1;
        retire_raw  = wait_done;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluFunct;
      end
      StRwb: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = 1'b1;
        retire_raw   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = AluSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcAluOut;
        retire_raw         = 1'b1;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcJump;
        retire_raw     = 1'b1;
      end
      StAddiWb: begin
        ctrl.reg_wr = 1'b1;
        retire_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_raw) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Strobes are masked during reset even though the state register already reads FETCH.
  assign ctrl_out = reset ? ctrl : '0;

  assign bus.PCWrite     = ctrl_out.pc_write;
  assign bus.PCWriteCond = ctrl_out.pc_write_cond;
  assign bus.pc_en       = ctrl_out.pc_write | (ctrl_out.pc_write_cond & bus.zero);
  assign bus.IorD        = ctrl_out.iord;
  assign bus.MemRead     = ctrl_out.mem_read;
  assign bus.MemWr       = ctrl_out.mem_wr;
  assign bus.IRWrite     = ctrl_out.ir_write;
  assign bus.M2R         = ctrl_out.m2r;
  assign bus.RegDst      = ctrl_out.reg_dst;
  assign bus.regWr       = ctrl_out.reg_wr;
  assign bus.ALUSrcA     = ctrl_out.alu_src_a;
  assign bus.ALUSrcB     = ctrl_out.alu_src_b;
  assign bus.ALUop       = ctrl_out.alu_op;
  assign bus.PCSource    = ctrl_out.pc_source;
  assign bus.retire      = reset & retire_raw;
  assign bus.trap        = (state_q == StTrap);
  assign bus.state       = state_q;
  assign bus.instr_cnt   = cnt_q;
endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: three instances (MEM_WAIT 0/2/3) driven from shared opcode/zero/reset.
module tb_mcpu_ctrl;
  import mcpu_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;

  always #5 CLK = ~CLK;

  mcpu_ctrl_if #(.CNT_W(4))  ifa ();
  mcpu_ctrl_if #(.CNT_W(16)) ifb ();
  mcpu_ctrl_if #(.CNT_W(16)) ifc ();

  assign ifa.opcode = op;
  assign ifa.zero   = zero;
  assign ifb.opcode = op;
  assign ifb.zero   = zero;
  assign ifc.opcode = op;
  assign ifc.zero   = zero;

  mcpu_ctrl #(.MEM_WAIT(0), .CNT_W(4))  dut_a (.CLK(CLK), .reset(rst_n), .bus(ifa));
  mcpu_ctrl #(.MEM_WAIT(2), .CNT_W(16)) dut_b (.CLK(CLK), .reset(rst_n), .bus(ifb));
  mcpu_ctrl #(.MEM_WAIT(3), .CNT_W(16)) dut_c (.CLK(CLK), .reset(rst_n), .bus(ifc));

  typedef struct packed {
    logic [15:0] cw;
    logic        pe;
    logic        rt;
    logic        tr;
    logic [3:0]  st;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    int          sel;
    logic [5:0]  op;
    logic        z;
    int          lat;
    logic [15:0] cw;
    logic        pe;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        vt[11];
  vec_t        sb[$];
  logic [3:0]  exp_st[12];
  logic [15:0] exp_cw[12];
  logic [15:0] CW_F0, CW_F1, CW_DEC, CW_MA, CW_MRD, CW_MWB, CW_MWR, CW_EX, CW_RWB, CW_BR,
               CW_J, CW_AWB;

  function automatic logic [15:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, pcs);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  function automatic obs_t get(input int sel);
    obs_t o;
    case (sel)
      0: begin
        o.cw  = {ifa.PCWrite, ifa.PCWriteCond, ifa.IorD, ifa.MemRead, ifa.MemWr, ifa.IRWrite,
                 ifa.M2R, ifa.RegDst, ifa.regWr, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUop,
                 ifa.PCSource};
        o.pe  = ifa.pc_en;  o.rt = ifa.retire;  o.tr = ifa.trap;  o.st = ifa.state;
        o.cnt = {12'd0, ifa.instr_cnt};
      end
      1: begin
        o.cw  = {ifb.PCWrite, ifb.PCWriteCond, ifb.IorD, ifb.MemRead, ifb.MemWr, ifb.IRWrite,
                 ifb.M2R, ifb.RegDst, ifb.regWr, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUop,
                 ifb.PCSource};
        o.pe  = ifb.pc_en;  o.rt = ifb.retire;  o.tr = ifb.trap;  o.st = ifb.state;
        o.cnt = ifb.instr_cnt;
      end
      default: begin
        o.cw  = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead, ifc.MemWr, ifc.IRWrite,
                 ifc.M2R, ifc.RegDst, ifc.regWr, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUop,
                 ifc.PCSource};
        o.pe  = ifc.pc_en;  o.rt = ifc.retire;  o.tr = ifc.trap;  o.st = ifc.state;
        o.cnt = ifc.instr_cnt;
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
  endtask

  // Release just after a rising edge so the next falling edge samples cycle 1.
  task automatic release_rst();
    @(posedge CLK);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_exp(input int i, input logic [3:0] s, input logic [15:0] w);
    exp_st[i] = s;
    exp_cw[i] = w;
  endtask

  task automatic expect_seq(input string nm, input int sel, input int n);
    obs_t ob;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      ob = get(sel);
      chk($sformatf("%s state c%0d", nm, c + 1), ob.st, exp_st[c]);
      chk($sformatf("%s ctrl c%0d", nm, c + 1), ob.cw, exp_cw[c]);
    end
  endtask

  task automatic trace(input string nm, input int sel, input logic [5:0] o_p, input int n);
    reset_pulse();
    op = o_p;
    release_rst();
    expect_seq(nm, sel, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t ob;
    vec_t e;
    logic got;
    int   nret;

    CW_F0  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    CW_F1  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    CW_DEC = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    CW_MA  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    CW_MRD = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    CW_MWB = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    CW_MWR = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    CW_EX  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
    CW_RWB = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
    CW_BR  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
    CW_J   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
    CW_AWB = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);

    // sel 0: MEM_WAIT=0, sel 1: MEM_WAIT=2
    vt[0]  = '{0, 6'b000000, 1'b1, 4, CW_RWB, 1'b0};
    vt[1]  = '{0, 6'b100011, 1'b0, 5, CW_MWB, 1'b0};
    vt[2]  = '{0, 6'b101011, 1'b0, 4, CW_MWR, 1'b0};
    vt[3]  = '{0, 6'b000100, 1'b1, 3, CW_BR,  1'b1};
    vt[4]  = '{0, 6'b000100, 1'b0, 3, CW_BR,  1'b0};
    vt[5]  = '{0, 6'b000010, 1'b0, 3, CW_J,   1'b1};
    vt[6]  = '{0, 6'b001000, 1'b1, 4, CW_AWB, 1'b0};
    vt[7]  = '{1, 6'b100011, 1'b0, 9, CW_MWB, 1'b0};
    vt[8]  = '{1, 6'b101011, 1'b0, 8, CW_MWR, 1'b0};
    vt[9]  = '{1, 6'b000000, 1'b1, 6, CW_RWB, 1'b0};
    vt[10] = '{1, 6'b000100, 1'b1, 5, CW_BR,  1'b1};

    for (int i = 0; i < 11; i++) begin
      reset_pulse();
      ob = get(vt[i].sel);
      chk($sformatf("v%0d reset outputs", i), {ob.cw, ob.pe, ob.rt, ob.tr, ob.st, ob.cnt}, 64'd0);
      op   = vt[i].op;
      zero = vt[i].z;
      release_rst();
      sb.push_back(vt[i]);
      got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
        @(negedge CLK);
        ob = get(vt[i].sel);
        if (ob.rt) begin
          got = 1'b1;
          e   = sb.pop_front();
          chk($sformatf("v%0d latency", i), c, e.lat);
          chk($sformatf("v%0d retire ctrl", i), ob.cw, e.cw);
          chk($sformatf("v%0d pc_en", i), ob.pe, e.pe);
        end
      end
      chk($sformatf("v%0d retire seen", i), got, 1);
      @(negedge CLK);
      ob = get(vt[i].sel);
      chk($sformatf("v%0d instr_cnt", i), ob.cnt, 1);
      chk($sformatf("v%0d back to fetch", i), ob.st, 0);
    end

    // R-type state walk, MEM_WAIT=0
    set_exp(0, 4'd0, CW_F1);
    set_exp(1, 4'd1, CW_DEC);
    set_exp(2, 4'd6, CW_EX);
    set_exp(3, 4'd7, CW_RWB);
    zero = 1'b0;
    trace("rtype", 0, OpR, 4);

    // lw with two wait states: IRWrite only in cycle 3, memory read in cycles 6-8
    set_exp(0, 4'd0, CW_F0);
    set_exp(1, 4'd0, CW_F0);
    set_exp(2, 4'd0, CW_F1);
    set_exp(3, 4'd1, CW_DEC);
    set_exp(4, 4'd2, CW_MA);
    set_exp(5, 4'd3, CW_MRD);
    set_exp(6, 4'd3, CW_MRD);
    set_exp(7, 4'd3, CW_MRD);
    set_exp(8, 4'd4, CW_MWB);
    trace("lw_w2", 1, OpLw, 9);

    // Illegal opcode: absorbing trap with all strobes quiet, even with zero high
    reset_pulse();
    op   = 6'b111111;
    zero = 1'b1;
    release_rst();
    @(negedge CLK);
    @(negedge CLK);
    for (int c = 3; c < 23; c++) begin
      @(negedge CLK);
      ob = get(0);
      chk($sformatf("trap flag c%0d", c), {ob.tr, ob.st}, {1'b1, 4'd12});
      chk($sformatf("trap strobes c%0d", c), {ob.cw, ob.pe, ob.rt}, 18'd0);
    end
    #1 rst_n = 1'b0;
    #1 ob = get(0);
    chk("trap cleared by reset", ob.tr, 0);
    op = OpR;
    @(negedge CLK);
    release_rst();
    @(negedge CLK);
    ob = get(0);
    chk("fetch after trap", {ob.st, ob.cw, ob.tr}, {4'd0, CW_F1, 1'b0});

    // Reset during a store with MEM_WAIT=3
    reset_pulse();
    op   = OpSw;
    zero = 1'b0;
    release_rst();
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge CLK);
      ob  = get(2);
      got = ob.rt;
    end
    chk("sw first retire", got, 1);
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge CLK);
      ob  = get(2);
      got = (ob.st == 4'd5);
    end
    chk("sw reach MEMWR", got, 1);
    chk("sw MEMWR strobes", ob.cw, CW_MWR);
    chk("sw count before reset", ob.cnt, 1);
    #1 rst_n = 1'b0;
    #1 ob = get(2);
    chk("sw async reset", {ob.cw, ob.pe, ob.rt, ob.st, ob.cnt}, 64'd0);
    @(negedge CLK);
    set_exp(0, 4'd0, CW_F0);
    set_exp(1, 4'd0, CW_F0);
    set_exp(2, 4'd0, CW_F0);
    set_exp(3, 4'd0, CW_F1);
    set_exp(4, 4'd1, CW_DEC);
    release_rst();
    expect_seq("post_reset", 2, 5);

    // 4-bit counter wraps after 16 back-to-back addi
    reset_pulse();
    op = OpAddi;
    release_rst();
    nret = 0;
    for (int c = 0; c < 100 && nret < 17; c++) begin
      @(negedge CLK);
      ob = get(0);
      if (ob.rt) begin
        nret++;
        if (nret >= 16) begin
          @(negedge CLK);
          ob = get(0);
          chk($sformatf("cnt after %0d addi", nret), ob.cnt, (nret == 16) ? 0 : 1);
        end
      end
    end
    chk("addi retire count", nret, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
